// File: rtl/eai_wb_arb_pkg.sv
// Shared constants for the EAI write-back path: default widths, grant encoding
// and the small helpers used by the arbiter.
package eai_wb_arb_pkg;

    localparam int EAI_WB_DW   = 32;
    localparam int EAI_RFIDX_W = 5;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_CORE = 2'b01;
    localparam gnt_t GNT_EAI  = 2'b10;

    // Counter increment that sticks at the limit instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
        sat_inc = (val >= lim) ? lim : val + 4'd1;
    endfunction

endpackage

// File: rtl/eai_wb_arb_if.sv
// Valid/ready write-back channel: one request stream carrying result data and
// destination register index.
interface eai_wb_arb_if
    import eai_wb_arb_pkg::*;
#(
    parameter int DW      = EAI_WB_DW,
    parameter int RFIDX_W = EAI_RFIDX_W
) ();

    logic               valid;
    logic               ready;
    logic [DW-1:0]      data;
    logic [RFIDX_W-1:0] rdidx;

    modport master (
        output valid,
        output data,
        output rdidx,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  rdidx,
        output ready
    );

endinterface

// File: rtl/eai_wb_outreg.sv
// Single-entry registered output stage toward the regfile write port.
// Drops writes to x0 while still letting the producer consume them.
module eai_wb_outreg
    import eai_wb_arb_pkg::*;
#(
    parameter int DW      = EAI_WB_DW,
    parameter int RFIDX_W = EAI_RFIDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_hs,
    input  logic [DW-1:0]      in_data,
    input  logic [RFIDX_W-1:0] in_rdidx,
    output logic               can_accept,
    eai_wb_arb_if.master       rf
);

    logic               valid_q, valid_d;
    logic [DW-1:0]      data_q, data_d;
    logic [RFIDX_W-1:0] rdidx_q, rdidx_d;
    logic               load;

    // Accept whenever the entry is empty or leaving this cycle, so a new write
    // replaces a draining one on the same edge.
    assign can_accept = ~valid_q | rf.ready;
    assign load       = in_hs & (in_rdidx != '0);

    always_comb begin
        valid_d = load | (valid_q & ~rf.ready);
        data_d  = data_q;
        rdidx_d = rdidx_q;
        if (load) begin
            data_d  = in_data;
            rdidx_d = in_rdidx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rdidx_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rdidx_q <= rdidx_d;
        end
    end

    assign rf.valid = valid_q;
    assign rf.data  = data_q;
    assign rf.rdidx = rdidx_q;

endmodule

// File: rtl/eai_wb_arb.sv
// Merges the EAI result stream and the core long-pipe write-back stream onto
// the regfile write port; core wins unless EAI has been starved too long.
module eai_wb_arb
    import eai_wb_arb_pkg::*;
#(
    parameter int DW         = EAI_WB_DW,
    parameter int RFIDX_W    = EAI_RFIDX_W,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    eai_wb_arb_if.slave  core_wb,
    eai_wb_arb_if.slave  eai_wb,
    eai_wb_arb_if.master rf_wb,
    output logic         starve_force
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic               can_accept;
    logic               cnt_at_lim;
    logic               core_hs, eai_hs;
    gnt_t               gnt;
    logic               in_hs;
    logic [DW-1:0]      in_data;
    logic [RFIDX_W-1:0] in_rdidx;

    assign cnt_at_lim   = (starve_cnt_q == STARVE_LIM);
    assign starve_force = eai_wb.valid & cnt_at_lim;

    // Readies are built from the other side's valid only, so neither ready
    // loops back through its own valid; the resulting handshakes match
    // "forced EAI, else core, else EAI".
    assign core_wb.ready = can_accept & ~starve_force;
    assign eai_wb.ready  = can_accept & (cnt_at_lim | ~core_wb.valid);

    assign core_hs = core_wb.valid & core_wb.ready;
    assign eai_hs  = eai_wb.valid & eai_wb.ready;
    assign gnt     = {eai_hs, core_hs};
    assign in_hs   = core_hs | eai_hs;

    always_comb begin
        in_data  = '0;
        in_rdidx = '0;
        case (gnt)
            GNT_CORE: begin
                in_data  = core_wb.data;
                in_rdidx = core_wb.rdidx;
            end
            GNT_EAI: begin
                in_data  = eai_wb.data;
                in_rdidx = eai_wb.rdidx;
            end
            default: begin
                in_data  = '0;
                in_rdidx = '0;
            end
        endcase
    end

    // Counts consecutive cycles EAI was pending but lost to core; a stalled
    // output neither helps nor hurts EAI, so the count holds.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (eai_hs || !eai_wb.valid) begin
            starve_cnt_d = '0;
        end else if (core_hs) begin
            starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    eai_wb_outreg #(
        .DW      (DW),
        .RFIDX_W (RFIDX_W)
    ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_hs      (in_hs),
        .in_data    (in_data),
        .in_rdidx   (in_rdidx),
        .can_accept (can_accept),
        .rf         (rf_wb)
    );

endmodule

// File: tb/tb_eai_wb_arb.sv
// Directed bench for eai_wb_arb: arbitration ratio, back-pressure, x0 drop,
// starvation counter clear and asynchronous reset.
module tb_eai_wb_arb;
    import eai_wb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic starve_force;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    eai_wb_arb_if #(.DW(32), .RFIDX_W(5)) core_if ();
    eai_wb_arb_if #(.DW(32), .RFIDX_W(5)) eai_if ();
    eai_wb_arb_if #(.DW(32), .RFIDX_W(5)) rf_if ();

    eai_wb_arb #(
        .DW         (32),
        .RFIDX_W    (5),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_wb      (core_if),
        .eai_wb       (eai_if),
        .rf_wb        (rf_if),
        .starve_force (starve_force)
    );

    task test_reset;
        rst_n         = 1'b1;
        core_if.valid = 1'b0;
        core_if.data  = '0;
        core_if.rdidx = '0;
        eai_if.valid  = 1'b0;
        eai_if.data   = '0;
        eai_if.rdidx  = '0;
        rf_if.ready   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", rf_if.valid); end
        checks++; if (rf_if.data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rf_if.data); end
        checks++; if (rf_if.rdidx !== 5'd0) begin errors++; $display("FAIL reset_rdidx got %0d want 0", rf_if.rdidx); end
        checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.starve_cnt_q); end
        checks++; if (starve_force !== 1'b0) begin errors++; $display("FAIL reset_force got %0b want 0", starve_force); end
        rst_n = 1'b1;
    endtask

    task test_core_only;
        core_if.valid = 1'b1;
        core_if.data  = 32'h11111111;
        core_if.rdidx = 5'd3;
        #1;
        checks++; if (core_if.ready !== 1'b1) begin errors++; $display("FAIL core_only_ready0 got %0b want 1", core_if.ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rf_if.valid !== 1'b1) begin errors++; $display("FAIL core_only_valid[%0d] got %0b want 1", i, rf_if.valid); end
            checks++; if (rf_if.data !== 32'h11111111) begin errors++; $display("FAIL core_only_data[%0d] got %h want 11111111", i, rf_if.data); end
            checks++; if (rf_if.rdidx !== 5'd3) begin errors++; $display("FAIL core_only_rdidx[%0d] got %0d want 3", i, rf_if.rdidx); end
            checks++; if (core_if.ready !== 1'b1) begin errors++; $display("FAIL core_only_ready[%0d] got %0b want 1", i, core_if.ready); end
        end
        core_if.valid = 1'b0;
        @(negedge clk);
        checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL core_only_drain got %0b want 0", rf_if.valid); end
    endtask

    task test_starve;
        logic exp_eai;
        logic prev_eai;
        prev_eai = 1'b0;
        checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL starve_cnt_start got %0d want 0", dut.starve_cnt_q); end
        core_if.valid = 1'b1;
        core_if.data  = 32'h22222222;
        core_if.rdidx = 5'd4;
        eai_if.valid  = 1'b1;
        eai_if.data   = 32'hA5A5A5A5;
        eai_if.rdidx  = 5'd9;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_eai = ((i % 5) == 4);
            checks++; if (core_if.ready !== !exp_eai) begin errors++; $display("FAIL starve_core_ready[%0d] got %0b want %0b", i, core_if.ready, !exp_eai); end
            checks++; if (eai_if.ready !== exp_eai) begin errors++; $display("FAIL starve_eai_ready[%0d] got %0b want %0b", i, eai_if.ready, exp_eai); end
            checks++; if (starve_force !== exp_eai) begin errors++; $display("FAIL starve_force[%0d] got %0b want %0b", i, starve_force, exp_eai); end
            if (i > 0) begin
                checks++;
                if (rf_if.valid !== 1'b1 || rf_if.data !== (prev_eai ? 32'hA5A5A5A5 : 32'h22222222)) begin
                    errors++;
                    $display("FAIL starve_out[%0d] got %0b/%h want 1/%h", i, rf_if.valid, rf_if.data, prev_eai ? 32'hA5A5A5A5 : 32'h22222222);
                end
            end
            prev_eai = exp_eai;
            @(negedge clk);
        end
        checks++; if (rf_if.data !== 32'hA5A5A5A5 || rf_if.rdidx !== 5'd9) begin errors++; $display("FAIL starve_eai_out got %h/%0d want a5a5a5a5/9", rf_if.data, rf_if.rdidx); end
        core_if.valid = 1'b0;
        eai_if.valid  = 1'b0;
    endtask

    task test_backpressure;
        logic [31:0] exp_data [5];
        logic [4:0]  exp_idx  [5];
        exp_data = '{32'h33330001, 32'h33330002, 32'h33330003, 32'h44444444, 32'h33330004};
        exp_idx  = '{5'd5, 5'd5, 5'd5, 5'd6, 5'd5};
        @(negedge clk);
        core_if.valid = 1'b1;
        core_if.data  = 32'h33333333;
        core_if.rdidx = 5'd5;
        eai_if.valid  = 1'b1;
        eai_if.data   = 32'h44444444;
        eai_if.rdidx  = 5'd6;
        rf_if.ready   = 1'b1;
        @(negedge clk);
        checks++; if (rf_if.valid !== 1'b1 || rf_if.data !== 32'h33333333) begin errors++; $display("FAIL bp_first got %0b/%h want 1/33333333", rf_if.valid, rf_if.data); end
        core_if.data = 32'h33330001;
        rf_if.ready  = 1'b0;
        #1;
        checks++; if (core_if.ready !== 1'b0 || eai_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready_now got %0b/%0b want 0/0", core_if.ready, eai_if.ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (core_if.ready !== 1'b0 || eai_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b/%0b want 0/0", i, core_if.ready, eai_if.ready); end
            checks++; if (rf_if.valid !== 1'b1 || rf_if.data !== 32'h33333333 || rf_if.rdidx !== 5'd5) begin errors++; $display("FAIL bp_hold[%0d] got %0b/%h/%0d want 1/33333333/5", i, rf_if.valid, rf_if.data, rf_if.rdidx); end
            checks++; if (dut.starve_cnt_q !== 4'd1) begin errors++; $display("FAIL bp_cnt[%0d] got %0d want 1", i, dut.starve_cnt_q); end
        end
        rf_if.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (rf_if.valid !== 1'b1 || rf_if.data !== exp_data[k] || rf_if.rdidx !== exp_idx[k]) begin errors++; $display("FAIL bp_seq[%0d] got %0b/%h/%0d want 1/%h/%0d", k, rf_if.valid, rf_if.data, rf_if.rdidx, exp_data[k], exp_idx[k]); end
            if (k != 3) core_if.data = exp_data[k] + 32'd1;
            if (k == 3) eai_if.valid = 1'b0;
            if (k == 4) core_if.valid = 1'b0;
            #1;
            checks++; if (starve_force !== (k == 2)) begin errors++; $display("FAIL bp_force[%0d] got %0b want %0b", k, starve_force, k == 2); end
        end
    endtask

    task test_x0;
        @(negedge clk);
        checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL x0_pre got %0b want 0", rf_if.valid); end
        eai_if.valid = 1'b1;
        eai_if.data  = 32'hDEADBEEF;
        eai_if.rdidx = 5'd0;
        #1;
        checks++; if (eai_if.ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b want 1", eai_if.ready); end
        @(negedge clk);
        checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL x0_dropped got %0b want 0", rf_if.valid); end
        eai_if.data  = 32'h77777777;
        eai_if.rdidx = 5'd7;
        #1;
        checks++; if (eai_if.ready !== 1'b1) begin errors++; $display("FAIL x0_next_ready got %0b want 1", eai_if.ready); end
        @(negedge clk);
        checks++; if (rf_if.valid !== 1'b1 || rf_if.data !== 32'h77777777 || rf_if.rdidx !== 5'd7) begin errors++; $display("FAIL x0_next_out got %0b/%h/%0d want 1/77777777/7", rf_if.valid, rf_if.data, rf_if.rdidx); end
        eai_if.valid = 1'b0;
        @(negedge clk);
        checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL x0_drain got %0b want 0", rf_if.valid); end
    endtask

    task test_counter_clear;
        logic exp_eai;
        core_if.valid = 1'b1;
        core_if.data  = 32'h55555555;
        core_if.rdidx = 5'd1;
        eai_if.data   = 32'h66666666;
        eai_if.rdidx  = 5'd2;
        for (int j = 0; j < 9; j++) begin
            eai_if.valid = (j != 3);
            #1;
            exp_eai = (j == 8);
            checks++; if (core_if.ready !== !exp_eai) begin errors++; $display("FAIL clr_core_ready[%0d] got %0b want %0b", j, core_if.ready, !exp_eai); end
            if (j != 3) begin
                checks++; if (eai_if.ready !== exp_eai) begin errors++; $display("FAIL clr_eai_ready[%0d] got %0b want %0b", j, eai_if.ready, exp_eai); end
            end
            checks++; if (starve_force !== exp_eai) begin errors++; $display("FAIL clr_force[%0d] got %0b want %0b", j, starve_force, exp_eai); end
            if (j == 4) begin
                checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", dut.starve_cnt_q); end
            end
            @(negedge clk);
        end
        checks++; if (rf_if.data !== 32'h66666666 || rf_if.rdidx !== 5'd2) begin errors++; $display("FAIL clr_eai_out got %h/%0d want 66666666/2", rf_if.data, rf_if.rdidx); end
        core_if.valid = 1'b0;
        eai_if.valid  = 1'b0;
    endtask

    task test_mid_reset;
        @(negedge clk);
        core_if.valid = 1'b1;
        core_if.data  = 32'h12345678;
        core_if.rdidx = 5'd8;
        eai_if.valid  = 1'b1;
        eai_if.data   = 32'h9ABCDEF0;
        eai_if.rdidx  = 5'd10;
        rf_if.ready   = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rf_if.valid !== 1'b1 || dut.starve_cnt_q !== 4'd3) begin errors++; $display("FAIL mrst_pre got %0b/%0d want 1/3", rf_if.valid, dut.starve_cnt_q); end
        rst_n = 1'b0;
        #1;
        checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b want 0", rf_if.valid); end
        checks++; if (rf_if.data !== 32'h0 || rf_if.rdidx !== 5'd0) begin errors++; $display("FAIL mrst_data got %h/%0d want 0/0", rf_if.data, rf_if.rdidx); end
        checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL mrst_cnt got %0d want 0", dut.starve_cnt_q); end
        core_if.valid = 1'b0;
        eai_if.valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (rf_if.valid !== 1'b0) begin errors++; $display("FAIL mrst_idle[%0d] got %0b want 0", i, rf_if.valid); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_core_only();
        test_starve();
        test_backpressure();
        test_x0();
        test_counter_clear();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
